// File: rtl/regfile_wb_pkg.sv
// Shared sizing and requester identifiers for the register-file write-back arbiter.
package regfile_wb_pkg;

    localparam int unsigned NUM_REQ     = 3;
    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned GRANT_W     = 2;

    localparam int unsigned REQ_ALU     = 0;
    localparam int unsigned REQ_MULTDIV = 1;
    localparam int unsigned REQ_LOAD    = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping to index 0.
module rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic found;

    // First pass covers ptr..N-1; the second pass only fires when nothing was found there.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (!found && req[i] && (i >= int'(32'(ptr)))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter in front of the register-file write port,
// with a one-cycle registered write and a saturating contention counter.
module regfile_wb_arbiter #(
    parameter int unsigned NUM_REQ = regfile_wb_pkg::NUM_REQ,
    parameter int unsigned ADDR_W  = regfile_wb_pkg::ADDR_W,
    parameter int unsigned DATA_W  = regfile_wb_pkg::DATA_W
) (
    input  logic                                 clock,
    input  logic                                 ctrl_reset_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]            req_reg,
    input  logic [NUM_REQ*DATA_W-1:0]            req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic                                 wb_hold,
    output logic                                 ctrl_writeEnable,
    output logic [ADDR_W-1:0]                    ctrl_writeReg,
    output logic [DATA_W-1:0]                    data_writeReg,
    output logic [regfile_wb_pkg::GRANT_W-1:0]   grant_id,
    output logic [regfile_wb_pkg::CNT_W-1:0]     conflict_cnt
);

    import regfile_wb_pkg::*;

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptrQ;
    logic [PTR_W-1:0]   winIdx;
    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0]  winReg;
    logic [DATA_W-1:0]  winData;
    logic [GRANT_W-1:0] winId;
    logic               transfer;
    logic               conflict;

    rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) uArb (
        .req   (req_valid),
        .ptr   (ptrQ),
        .grant (grant)
    );

    // Reset gating keeps ready low while the arbiter is held in reset.
    assign req_ready = (wb_hold || !ctrl_reset_n) ? '0 : grant;
    assign transfer  = |req_ready;
    assign conflict  = |(req_valid & ~req_ready);

    // Mux out the winner's payload from the packed request buses.
    always_comb begin
        winIdx  = '0;
        winReg  = '0;
        winData = '0;
        winId   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (req_ready[i]) begin
                winIdx  = PTR_W'(i);
                winReg  = req_reg[i*ADDR_W +: ADDR_W];
                winData = req_data[i*DATA_W +: DATA_W];
                winId   = GRANT_W'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            ptrQ             <= '0;
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
            grant_id         <= '0;
            conflict_cnt     <= '0;
        end else begin
            if (transfer) begin
                // Register 0 is hard-wired: the transfer completes but never writes.
                ctrl_writeEnable <= |winReg;
                ctrl_writeReg    <= winReg;
                data_writeReg    <= winData;
                grant_id         <= winId;
                ptrQ             <= (32'(winIdx) == NUM_REQ - 1) ? '0 : winIdx + PTR_W'(1);
            end else begin
                ctrl_writeEnable <= 1'b0;
            end
            if (conflict && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

endmodule
